// File: rtl/arf_pkg.sv
// Shared constants for the address register file: function codes and
// the fixed roles of the low register indices.
package arf_pkg;

  localparam logic [2:0] FS_HOLD = 3'b000;
  localparam logic [2:0] FS_LOAD = 3'b001;
  localparam logic [2:0] FS_CLR  = 3'b010;
  localparam logic [2:0] FS_INC  = 3'b011;
  localparam logic [2:0] FS_DEC  = 3'b100;
  localparam logic [2:0] FS_ADD  = 3'b101;
  localparam logic [2:0] FS_LDL  = 3'b110;
  localparam logic [2:0] FS_LDH  = 3'b111;

  localparam int IDX_PC = 0;
  localparam int IDX_SP = 1;
  localparam int IDX_AR = 2;

endpackage

// File: rtl/addr_reg_file_p_if.sv
// Control/data bundle between the datapath and the address register file.
interface addr_reg_file_p_if #(
  parameter int WIDTH    = 16,
  parameter int NUM_REGS = 4,
  parameter int SEL_W    = 2
);
  logic [WIDTH-1:0]    I;
  logic [NUM_REGS-1:0] RegSel;
  logic [2:0]          FunSel;
  logic [SEL_W-1:0]    OutCSel;
  logic [SEL_W-1:0]    OutDSel;
  logic                ClearFlags;
  logic [WIDTH-1:0]    OutC;
  logic [WIDTH-1:0]    OutD;
  logic                SpOverflow;
  logic                SpUnderflow;
  logic                Wrap;

  modport master (
    output I, RegSel, FunSel, OutCSel, OutDSel, ClearFlags,
    input  OutC, OutD, SpOverflow, SpUnderflow, Wrap
  );

  modport slave (
    input  I, RegSel, FunSel, OutCSel, OutDSel, ClearFlags,
    output OutC, OutD, SpOverflow, SpUnderflow, Wrap
  );
endinterface

// File: rtl/addr_reg_cell.sv
// One address register with its function unit. Exposes the value it will
// take at the next edge so the top level can range-check it beforehand.
module addr_reg_cell
  import arf_pkg::*;
#(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [2:0]       fun_sel,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] nxt,
  output logic             wrap
);

  localparam int HW = WIDTH / 2;

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH:0]   sum;

  // Offset add wraps when the raw WIDTH-bit adder carries out.
  assign sum = {1'b0, q_q} + {1'b0, data};

  // Next value and wrap indication for the selected function.
  always_comb begin
    q_d  = q_q;
    wrap = 1'b0;
    if (en) begin
      case (fun_sel)
        FS_LOAD: q_d = data;
        FS_CLR:  q_d = '0;
        FS_INC: begin
          q_d  = q_q + 1'b1;
          wrap = &q_q;
        end
        FS_DEC: begin
          q_d  = q_q - 1'b1;
          wrap = ~|q_q;
        end
        FS_ADD: begin
          q_d  = sum[WIDTH-1:0];
          wrap = sum[WIDTH];
        end
        FS_LDL:  q_d = {q_q[WIDTH-1:HW], data[HW-1:0]};
        FS_LDH:  q_d = {data[HW-1:0], q_q[HW-1:0]};
        default: q_d = q_q;
      endcase
    end
  end

  // Register update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) q_q <= RESET_VAL;
    else        q_q <= q_d;
  end

  assign q   = q_q;
  assign nxt = q_d;

endmodule

// File: rtl/addr_reg_file_p.sv
// Address register bank (PC/SP/AR/general) with SP bounds flags, a wrap
// pulse and two combinational read ports.
module addr_reg_file_p
  import arf_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter int               NUM_REGS    = 4,
  parameter int               SEL_W       = 2,
  parameter logic [WIDTH-1:0] SP_RESET    = 16'hFFFF,
  parameter logic [WIDTH-1:0] SP_LIMIT_LO = 16'hFF00,
  parameter logic [WIDTH-1:0] SP_LIMIT_HI = 16'hFFFF
) (
  input  logic              Clock,
  input  logic              Reset,
  addr_reg_file_p_if.slave  bus
);

  logic [WIDTH-1:0]    q_a   [NUM_REGS];
  logic [WIDTH-1:0]    nxt_a [NUM_REGS];
  logic [NUM_REGS-1:0] wrap_a;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_cell
    addr_reg_cell #(
      .WIDTH     (WIDTH),
      .RESET_VAL ((k == IDX_SP) ? SP_RESET : {WIDTH{1'b0}})
    ) u_cell (
      .clk     (Clock),
      .rst_n   (Reset),
      .en      (bus.RegSel[k]),
      .fun_sel (bus.FunSel),
      .data    (bus.I),
      .q       (q_a[k]),
      .nxt     (nxt_a[k]),
      .wrap    (wrap_a[k])
    );
  end

  logic           sp_upd;
  logic [WIDTH:0] hi_diff;
  logic [WIDTH:0] lo_diff;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;
  logic           wrap_q, wrap_d;

  // Range checks use the borrow of a widened subtract so a limit at the
  // extreme of the range does not turn into a constant comparison.
  assign sp_upd  = bus.RegSel[IDX_SP] && (bus.FunSel != FS_HOLD);
  assign hi_diff = {1'b0, SP_LIMIT_HI} - {1'b0, nxt_a[IDX_SP]};
  assign lo_diff = {1'b0, nxt_a[IDX_SP]} - {1'b0, SP_LIMIT_LO};

  // Sticky flags: clear first, then a new violation in the same cycle wins.
  always_comb begin
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    wrap_d = |wrap_a;
    if (bus.ClearFlags) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    if (sp_upd && hi_diff[WIDTH]) ovf_d = 1'b1;
    if (sp_upd && lo_diff[WIDTH]) unf_d = 1'b1;
  end

  // Flag registers.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      wrap_q <= wrap_d;
    end
  end

  logic [WIDTH-1:0] out_c;
  logic [WIDTH-1:0] out_d;

  // Read muxes; an index with no register behind it reads zero.
  always_comb begin
    out_c = '0;
    out_d = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (bus.OutCSel == SEL_W'(k)) out_c = q_a[k];
      if (bus.OutDSel == SEL_W'(k)) out_d = q_a[k];
    end
  end

  assign bus.OutC        = out_c;
  assign bus.OutD        = out_d;
  assign bus.SpOverflow  = ovf_q;
  assign bus.SpUnderflow = unf_q;
  assign bus.Wrap        = wrap_q;

endmodule
